down_timer: RTL and testbench

- Loadable down-counter/timer: the counting-down complement of the team's up-counter with carry-out.
- Accepts a start value over a valid/ready load interface and counts down to 0 on enabled cycles.
- Flags terminal count with a borrow-out (bo) pulse.
- Runs one-shot or auto-reload; used as a programmable tick/timeout source beside the up-counter.

---
 rtl/down_timer_pkg.sv | 19 +
 rtl/down_timer.sv | 103 ++++++++++
 tb/tb_down_timer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
// Shared types and helpers for the loadable down-timer.
package down_timer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } timer_state_t;

   // Limit a requested start value to the legal count range 0..m-1.
   // When m is a power of two every W-bit value is already in range.
   function automatic int unsigned clamp_load(input int unsigned value,
                                              input int unsigned m);
      if (value > (m - 1)) begin
         return m - 1;
      end
      return value;
   endfunction

endpackage : down_timer_pkg

// File: rtl/down_timer.sv
// Loadable down-counter with borrow-out, one-shot or auto-reload operation.
module down_timer
   import down_timer_pkg::*;
#(
   parameter  int unsigned M = 32,
   localparam int unsigned W = $clog2(M)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [W-1:0] load_value,
   input  logic         auto_reload,
   input  logic         abort,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         bo,
   output logic         done,
   output logic         busy
);

   timer_state_t r_state;
   logic [W-1:0] r_cnt;
   logic [W-1:0] r_reload;
   logic         r_mode;
   logic         r_done;

   timer_state_t w_state_nxt;
   logic [W-1:0] w_cnt_nxt;
   logic [W-1:0] w_reload_nxt;
   logic         w_mode_nxt;
   logic         w_done_nxt;
   logic [W-1:0] w_load_clamped;
   logic         w_terminal;

   assign w_load_clamped = W'(clamp_load(32'(load_value), M));

   // Terminal count: running, enabled, at zero and not being cancelled.
   assign w_terminal = (r_state == RUN) && en && (r_cnt == '0) && !abort;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_reload <= '0;
         r_mode   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_reload <= w_reload_nxt;
         r_mode   <= w_mode_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Next-state and datapath update; abort outranks enable, which outranks counting.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_reload_nxt = r_reload;
      w_mode_nxt   = r_mode;
      w_done_nxt   = 1'b0;

      case (r_state)
         IDLE: begin
            if (load_valid) begin
               w_cnt_nxt    = w_load_clamped;
               w_reload_nxt = w_load_clamped;
               w_mode_nxt   = auto_reload;
               w_state_nxt  = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (!en) begin
               w_cnt_nxt = r_cnt;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - W'(1);
            end else if (r_mode) begin
               w_cnt_nxt = r_reload;
            end else begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign load_ready = (r_state == IDLE);
   assign busy       = (r_state == RUN);
   assign bo         = w_terminal;
   assign cnt        = r_cnt;
   assign done       = r_done;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: driver queues per-cycle expectations, monitor checks them.
module tb_down_timer;

   logic       clk;
   logic       rst;
   logic       load_valid;
   logic [4:0] load_value;
   logic       auto_reload;
   logic       abort;
   logic       en;

   logic       load_ready, bo, done, busy;
   logic [4:0] cnt;
   logic       load_ready20, bo20, done20, busy20;
   logic [4:0] cnt20;

   typedef struct packed {
      logic [4:0] cnt;
      logic       bo;
      logic       done;
      logic       busy;
      logic       rdy;
      logic       chk20;
      logic [4:0] c20;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   bit   drv_done = 0;

   down_timer #(.M(32)) u_dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_value(load_value), .auto_reload(auto_reload), .abort(abort), .en(en),
      .cnt(cnt), .bo(bo), .done(done), .busy(busy)
   );

   down_timer #(.M(20)) u_dut20 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready20),
      .load_value(load_value), .auto_reload(auto_reload), .abort(abort), .en(en),
      .cnt(cnt20), .bo(bo20), .done(done20), .busy(busy20)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t e(input int c, input bit b, input bit d, input bit bz);
      exp_t x;
      x.cnt   = 5'(c);
      x.bo    = b;
      x.done  = d;
      x.busy  = bz;
      x.rdy   = !bz;
      x.chk20 = 1'b0;
      x.c20   = 5'd0;
      return x;
   endfunction

   function automatic exp_t e20(input exp_t x, input int c20);
      exp_t y;
      y       = x;
      y.chk20 = 1'b1;
      y.c20   = 5'(c20);
      return y;
   endfunction

   // One clock cycle of stimulus plus the outputs expected during that cycle.
   task automatic cyc(input logic r, input logic lv, input int v, input logic ar,
                      input logic ab, input logic en_i, input exp_t x);
      @(posedge clk);
      #1;
      rst         = r;
      load_valid  = lv;
      load_value  = 5'(v);
      auto_reload = ar;
      abort       = ab;
      en          = en_i;
      sb.push_back(x);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle; compare at the falling edge.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (bo) chk("bo_implies_cnt0", int'(cnt), 0);
         if (bo20) chk("bo20_implies_cnt0", int'(cnt20), 0);
         if (sb.size() != 0) begin
            x = sb.pop_front();
            chk("cnt", int'(cnt), int'(x.cnt));
            chk("bo", int'(bo), int'(x.bo));
            chk("done", int'(done), int'(x.done));
            chk("busy", int'(busy), int'(x.busy));
            chk("load_ready", int'(load_ready), int'(x.rdy));
            if (x.chk20) chk("cnt_m20", int'(cnt20), int'(x.c20));
         end
      end
   end

   // Driver: directed sequences with hand-derived expectations.
   initial begin
      rst = 1'b1; load_valid = 1'b0; load_value = '0;
      auto_reload = 1'b0; abort = 1'b0; en = 1'b0;
      repeat (2) @(posedge clk);

      // reset held with a pending load
      repeat (3) cyc(1, 1, 5, 0, 0, 1, e(0, 0, 0, 0));

      // one-shot 5: accepted on first edge after reset falls
      cyc(0, 1, 5, 0, 0, 1, e(0, 0, 0, 0));
      for (int c = 5; c >= 0; c--) cyc(0, 0, 0, 0, 0, 1, e(c, c == 0, 0, 1));
      cyc(0, 0, 0, 0, 0, 1, e(0, 0, 1, 0));

      // auto-reload 3 for 12 enabled cycles, then abort
      cyc(0, 1, 3, 1, 0, 0, e(0, 0, 0, 0));
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 1, e(3 - (i % 4), (i % 4) == 3, 0, 1));
      cyc(0, 0, 0, 0, 1, 1, e(3, 0, 0, 1));
      cyc(0, 0, 0, 0, 0, 1, e(0, 0, 0, 0));

      // enable gating: one-shot 10, en low for 10 cycles at cnt=2
      cyc(0, 1, 10, 0, 0, 1, e(0, 0, 0, 0));
      for (int c = 10; c >= 3; c--) cyc(0, 0, 0, 0, 0, 1, e(c, 0, 0, 1));
      repeat (10) cyc(0, 0, 0, 0, 0, 0, e(2, 0, 0, 1));
      for (int c = 2; c >= 0; c--) cyc(0, 0, 0, 0, 0, 1, e(c, c == 0, 0, 1));

      // load 0 on the done cycle: bo on the first enabled cycle
      cyc(0, 1, 0, 0, 0, 0, e(0, 0, 1, 0));
      cyc(0, 0, 0, 0, 0, 1, e(0, 1, 0, 1));

      // load 7 on the done cycle, then hold valid through RUN
      cyc(0, 1, 7, 0, 0, 0, e(0, 0, 1, 0));
      for (int c = 7; c >= 0; c--) cyc(0, 1, 2, 0, 0, 1, e(c, c == 0, 0, 1));
      cyc(0, 1, 2, 0, 0, 0, e(0, 0, 1, 0));
      for (int c = 2; c >= 1; c--) cyc(0, 0, 0, 0, 0, 1, e(c, 0, 0, 1));
      // abort at terminal count suppresses bo and done
      cyc(0, 0, 0, 0, 1, 1, e(0, 0, 0, 1));
      cyc(0, 0, 0, 0, 0, 1, e(0, 0, 0, 0));

      // abort at cnt=7; abort/en in IDLE ignored
      cyc(0, 1, 9, 0, 0, 0, e(0, 0, 0, 0));
      cyc(0, 0, 0, 0, 0, 1, e(9, 0, 0, 1));
      cyc(0, 0, 0, 0, 0, 1, e(8, 0, 0, 1));
      cyc(0, 0, 0, 0, 1, 1, e(7, 0, 0, 1));
      cyc(0, 0, 0, 0, 1, 1, e(0, 0, 0, 0));

      // reset at cnt=7
      cyc(0, 1, 9, 0, 0, 0, e(0, 0, 0, 0));
      cyc(0, 0, 0, 0, 0, 1, e(9, 0, 0, 1));
      cyc(0, 0, 0, 0, 0, 1, e(8, 0, 0, 1));
      cyc(1, 0, 0, 0, 0, 1, e(7, 0, 0, 1));
      cyc(0, 0, 0, 0, 0, 1, e(0, 0, 0, 0));

      // clamp: 25 loads as 25 with M=32, 19 with M=20
      cyc(0, 1, 25, 0, 0, 0, e20(e(0, 0, 0, 0), 0));
      cyc(0, 0, 0, 0, 0, 0, e20(e(25, 0, 0, 1), 19));
      cyc(0, 0, 0, 0, 1, 0, e20(e(25, 0, 0, 1), 19));
      cyc(0, 0, 0, 0, 0, 0, e20(e(0, 0, 0, 0), 0));

      drv_done = 1'b1;
   end

   // Completion: drain the scoreboard within a bounded number of cycles.
   initial begin
      wait (drv_done);
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog against a stalled run.
   initial begin
      #200000;
      $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_down_timer
